ssd_score_driver: RTL and testbench

//  Downstream consumer of the SSD refresh clock divider. Converts the binary game score to BCD.

---
 rtl/ssd_pkg.sv | 45 ++++
 rtl/ssd_bin2bcd_seq.sv | 80 ++++++++
 rtl/ssd_score_driver.sv | 131 +++++++++++++
 tb/tb_ssd_score_driver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: conversion FSM encoding, seven-segment patterns
// ({g,f,e,d,c,b,a}, active-low) and digit geometry.
package ssd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } conv_state_t;

  localparam int NIB_W  = 4;
  localparam int DIGITS = 4;
  localparam int BCD_W  = NIB_W * DIGITS;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_of(
    input logic [NIB_W-1:0] d
  );
    case (d)
      4'd0:    seg_of = SEG_0;
      4'd1:    seg_of = SEG_1;
      4'd2:    seg_of = SEG_2;
      4'd3:    seg_of = SEG_3;
      4'd4:    seg_of = SEG_4;
      4'd5:    seg_of = SEG_5;
      4'd6:    seg_of = SEG_6;
      4'd7:    seg_of = SEG_7;
      4'd8:    seg_of = SEG_8;
      4'd9:    seg_of = SEG_9;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ssd_bin2bcd_seq.sv
// ssd_bin2bcd_seq: sequential double-dabble, one bit per cycle.
// Ports: clk_in, rst_n, start/value in; busy, done, result out.
// done is high on the last SHIFT cycle; result is the final BCD then.
module ssd_bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int SCORE_W = 14
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SCORE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   result
);

  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCORE_W - 1);

  conv_state_t        state;
  logic [SCORE_W-1:0] sh;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt;

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[i*NIB_W +: NIB_W] >= 4'd5)
        adj[i*NIB_W +: NIB_W] =
          acc[i*NIB_W +: NIB_W] + 4'd3;
      else
        adj[i*NIB_W +: NIB_W] =
          acc[i*NIB_W +: NIB_W];
    end
  end

  assign result = {adj[BCD_W-2:0], sh[SCORE_W-1]};
  assign done   = (state == ST_SHIFT) && (cnt == LAST);
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sh    <= value;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          acc   <= '0;
          cnt   <= '0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          acc <= result;
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
          if (done) begin
            if (start) begin
              sh    <= value;
              state <= ST_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ssd_score_driver.sv
// ssd_score_driver: score -> BCD -> 4-digit multiplexed SSD drive.
// Ports: clk_in, rst_n, scan_clk, score, score_valid; busy, an, seg, dp.
// Option SSD_LZ_BLANK_EN: blank leading zero digits 3..1.
module ssd_score_driver
  import ssd_pkg::*;
#(
  parameter int SCORE_W     = 14,
  parameter int MAX_SCORE   = 9999,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               scan_clk,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   scan_prev;
  logic                   tick;

  logic [SCORE_W-1:0] clamped;
  logic [SCORE_W-1:0] pend_val;
  logic               pend;
  logic               conv_start;
  logic [SCORE_W-1:0] conv_val;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_res;
  logic [BCD_W-1:0]   disp;

  logic [1:0]       idx;
  logic [1:0]       idx_nx;
  logic [NIB_W-1:0] digit;
  logic [6:0]       seg_nx;

  assign dp = 1'b1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      scan_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], scan_clk};
      scan_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~scan_prev;

  assign clamped = (score > MAX_V) ? MAX_V : score;

  // A finishing conversion chains straight into the next one;
  // a strobe in that same cycle is newer than the pending value.
  always_comb begin
    conv_start = 1'b0;
    conv_val   = clamped;
    if (!busy) begin
      conv_start = score_valid;
    end else if (conv_done) begin
      conv_start = score_valid | pend;
      conv_val   = score_valid ? clamped : pend_val;
    end
  end

  ssd_bin2bcd_seq #(
    .SCORE_W(SCORE_W)
  ) u_bcd (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .start  (conv_start),
    .value  (conv_val),
    .busy   (busy),
    .done   (conv_done),
    .result (conv_res)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_val <= '0;
      disp     <= '0;
    end else begin
      if (conv_done) begin
        pend <= 1'b0;
        disp <= conv_res;
      end else if (score_valid && busy) begin
        pend     <= 1'b1;
        pend_val <= clamped;
      end
    end
  end

  assign idx_nx = idx + 2'd1;
  assign digit  = disp[{idx_nx, 2'b00} +: NIB_W];

`ifdef SSD_LZ_BLANK_EN
  logic [DIGITS-1:0] lz;

  always_comb begin
    logic run;
    run = 1'b1;
    lz  = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run   = run && (disp[i*NIB_W +: NIB_W] == '0);
      lz[i] = run;
    end
    seg_nx = lz[idx_nx] ? SEG_BLANK : seg_of(digit);
  end
`else
  assign seg_nx = seg_of(digit);
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else if (tick) begin
      idx <= idx_nx;
      an  <= ~(4'b0001 << idx_nx);
      seg <= seg_nx;
    end
  end

endmodule

// File: tb/tb_ssd_score_driver.sv
// tb_ssd_score_driver: directed stimulus, behavioural model
// compared every cycle, plus literal frame expectations.
module tb_ssd_score_driver;

  localparam int W = 14;
  localparam int S = 2;

  logic         clk_in = 1'b0;
  logic         rst_n = 1'b0;
  logic         scan_clk = 1'b0;
  logic         score_valid = 1'b0;
  logic [W-1:0] score = '0;
  logic         busy;
  logic         dp;
  logic [3:0]   an;
  logic [6:0]   seg;

  int n_chk = 0;
  int n_pass = 0;
  int busy_cyc = 0;
  int tb_idx = 0;

  always #5 clk_in = ~clk_in;

  ssd_score_driver #(
    .SCORE_W(W),
    .MAX_SCORE(9999),
    .SYNC_STAGES(S)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .scan_clk    (scan_clk),
    .score       (score),
    .score_valid (score_valid),
    .busy        (busy),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  function automatic logic [6:0] seg_lut(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int disp, int idx);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
`ifdef SSD_LZ_BLANK_EN
    if (idx > 0 && disp < p) return 7'h7F;
`endif
    return seg_lut((disp / p) % 10);
  endfunction

  function automatic int clamp(int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  // Model: busy lasts W+1 cycles per conversion, display
  // value lands when it ends, scan ticks S+1 edges late.
  int         m_left = 0;
  int         m_conv = 0;
  int         m_disp = 0;
  int         m_pval = 0;
  int         m_idx = 0;
  bit         m_pend = 1'b0;
  logic [3:0] m_an = 4'hF;
  logic [6:0] m_seg = 7'h7F;
  logic [S:0] m_hist = '0;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_conv = 0;
      m_disp = 0;
      m_pval = 0;
      m_pend = 1'b0;
      m_idx  = 0;
      m_an   = 4'hF;
      m_seg  = 7'h7F;
      m_hist = '0;
    end else begin
      if (m_hist[S-1] && !m_hist[S]) begin
        m_idx = (m_idx + 1) % 4;
        m_an  = 4'hF ^ (4'd1 << m_idx);
        m_seg = exp_seg(m_disp, m_idx);
      end
      m_hist = {m_hist[S-1:0], scan_clk};
      if (m_left == 0) begin
        if (score_valid) begin
          m_conv = clamp(int'(score));
          m_left = W + 1;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_disp = m_conv;
          if (score_valid || m_pend) begin
            m_conv = score_valid ? clamp(int'(score)) : m_pval;
            m_pend = 1'b0;
            m_left = W + 1;
          end
        end else if (score_valid) begin
          m_pend = 1'b1;
          m_pval = clamp(int'(score));
        end
      end
    end
  end

  task automatic chk(string name, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, exp);
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic strobe(int v);
    score       = W'(v);
    score_valid = 1'b1;
    cyc(1);
    score_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      cyc(1);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic one_tick();
    scan_clk = 1'b1;
    cyc(4);
    scan_clk = 1'b0;
    cyc(4);
    tb_idx = (tb_idx + 1) % 4;
  endtask

  task automatic frame(string nm, logic [6:0] d3, logic [6:0] d2,
                       logic [6:0] d1, logic [6:0] d0);
    logic [3:0] ea;
    logic [6:0] es;
    for (int k = 0; k < 4; k++) begin
      one_tick();
      ea = ~(4'b0001 << tb_idx);
      case (tb_idx)
        0: es = d0;
        1: es = d1;
        2: es = d2;
        default: es = d3;
      endcase
      chk({nm, "_an"}, int'(an), int'(ea));
      chk({nm, "_seg"}, int'(seg), int'(es));
      chk({nm, "_model"}, int'(m_seg), int'(es));
    end
  endtask

  localparam logic [6:0] Z =
`ifdef SSD_LZ_BLANK_EN
    7'h7F;
`else
    7'b1000000;
`endif

  initial begin
    logic [3:0] ea;
    fork
      forever begin
        @(negedge clk_in);
        if (rst_n) begin
          if (busy) busy_cyc++;
          chk("cyc_an", int'(an), int'(m_an));
          chk("cyc_seg", int'(seg), int'(m_seg));
          chk("cyc_busy", int'(busy), int'(m_left != 0));
          chk("cyc_dp", int'(dp), 1);
        end
      end
    join_none

    cyc(2);
    chk("rst_an", int'(an), 'hF);
    chk("rst_seg", int'(seg), 'h7F);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dp", int'(dp), 1);
    rst_n = 1'b1;
    cyc(2);
    chk("pre_tick_an", int'(an), 'hF);

    busy_cyc = 0;
    strobe(1234);
    wait_idle();
    chk("t1_busy_len", busy_cyc, 15);
    frame("t1", 7'b1111001, 7'b0100100,
          7'b0110000, 7'b0011001);

    strobe(16383);
    wait_idle();
    frame("t2", 7'b0010000, 7'b0010000,
          7'b0010000, 7'b0010000);

    busy_cyc = 0;
    strobe(500);
    cyc(4);
    strobe(77);
    wait_idle();
    chk("t3_busy_len", busy_cyc, 30);
    frame("t3", Z, Z, 7'b1111000, 7'b1111000);

    for (int k = 0; k < 20; k++) begin
      one_tick();
      ea = ~(4'b0001 << tb_idx);
      chk("t4_an", int'(an), int'(ea));
    end

    strobe(4321);
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_an", int'(an), 'hF);
    chk("t5_seg", int'(seg), 'h7F);
    chk("t5_busy", int'(busy), 0);
    chk("t5_dp", int'(dp), 1);
    cyc(2);
    rst_n = 1'b1;
    tb_idx = 0;
    cyc(1);
    chk("t5_busy_after", int'(busy), 0);
    frame("t5", Z, Z, Z, 7'b1000000);

    strobe(7);
    wait_idle();
    frame("t6", Z, Z, Z, 7'b1111000);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
